// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode, state and mux-select encodings for the multicycle sequencer
package ctrl_pkg;
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12,
    S_FAULT     = 4'd13
  } stateT;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating memory-wait counter; timeout fires on the LIMIT-th unanswered cycle
module mem_wait_timer #(
  parameter int LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  logic [7:0] count;
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable && count != 8'(LIMIT)) count <= count + 8'd1;
  assign timeout = enable && count == 8'(LIMIT - 1);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencer for the shared-ALU 16-bit datapath with memory timeout and retire count
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             halted,
  output logic             bus_error,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);
  stateT state, nextState;
  logic timeout, inWait, pcWr, memRd, memWr, irWr, regWr;
  assign inWait = state == S_FETCH || state == S_MEM_READ || state == S_MEM_WRITE;
  mem_wait_timer #(.LIMIT(WAIT_LIMIT)) waitTimer (
    .clock  (clock),
    .reset  (reset),
    .clear  (mem_ready || state != nextState),
    .enable (inWait && !mem_ready),
    .timeout(timeout)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_FETCH;
    else state <= nextState;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      retired   <= '0;
      bus_error <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (state != S_FETCH && nextState == S_FETCH) retired <= retired + 1'b1;
      if (timeout) bus_error <= 1'b1;
      if (state == S_DECODE && nextState == S_FAULT) illegal <= 1'b1;
    end
  always_comb begin
    nextState = state;
    case (state)
      S_FETCH:     nextState = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      S_DECODE:
        case (opcode)
          OP_R:         nextState = S_EXECUTE;
          OP_LW, OP_SW: nextState = S_MEM_ADDR;
          OP_BEQ:       nextState = S_BRANCH;
          OP_ADDI:      nextState = S_ADDI_EX;
          OP_J:         nextState = S_JUMP;
          OP_HALT:      nextState = S_HALT;
          default:      nextState = S_FAULT;
        endcase
      S_MEM_ADDR:  nextState = opcode == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nextState = mem_ready ? S_MEM_WB : timeout ? S_FAULT : S_MEM_READ;
      S_MEM_WRITE: nextState = mem_ready ? S_FETCH : timeout ? S_FAULT : S_MEM_WRITE;
      S_EXECUTE:   nextState = S_R_WB;
      S_ADDI_EX:   nextState = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: nextState = S_FETCH;
      S_HALT:      nextState = S_HALT;
      default:     nextState = S_FAULT;
    endcase
  end
  always_comb begin
    pcWr       = 1'b0;
    iord       = 1'b0;
    memRd      = 1'b0;
    memWr      = 1'b0;
    irWr       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    regWr      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_ADD;
    pc_source  = PC_ALU;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        memRd     = 1'b1;
        alu_src_b = SRCB_ONE;
        irWr      = mem_ready;
        pcWr      = mem_ready;
      end
      S_DECODE:    alu_src_b = SRCB_IMM;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        memRd = 1'b1;
        iord  = 1'b1;
      end
      S_MEM_WB: begin
        regWr      = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        memWr = 1'b1;
        iord  = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        regWr   = 1'b1;
        reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PC_ALUOUT;
        pcWr      = zero;
      end
      S_JUMP: begin
        pc_source = PC_JUMP;
        pcWr      = 1'b1;
      end
      S_ADDI_WB:   regWr = 1'b1;
      S_HALT:      halted = 1'b1;
      default:     ;
    endcase
  end
  // Async reset lands in FETCH, whose Moore outputs would otherwise request memory.
  assign pc_write  = pcWr && !reset;
  assign mem_read  = memRd && !reset;
  assign mem_write = memWr && !reset;
  assign ir_write  = irWr && !reset;
  assign reg_write = regWr && !reset;
  assign state_dbg = state;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction streams checked against a per-instruction state-trace model
module tb_multicycle_control;
  localparam int WL = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic halted, bus_error, illegal;
  logic [CW-1:0] retired;
  logic [3:0] state_dbg;
  logic [15:0] act;
  logic [4:0] enables;
  int vectors = 0;
  int miscompares = 0;
  logic [CW-1:0] expRetired = '0;

  typedef struct {int st; logic rdy;} stepT;

  multicycle_control #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clock(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .halted(halted), .bus_error(bus_error), .illegal(illegal), .retired(retired),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_source, halted};
  assign enables = {pc_write, mem_read, mem_write, ir_write, reg_write};

  // Control-signal table per state: {pw,iord,mr,mw,irw,rdst,m2r,rw,srca,srcb,aluop,pcsrc,halted}
  function automatic logic [15:0] expOut(int s, logic r, logic z);
    logic pw, io, mr, mw, iw, rd, m2r, rw, sa, h;
    logic [1:0] sb, ao, ps;
    {pw, io, mr, mw, iw, rd, m2r, rw, sa, h} = '0;
    {sb, ao, ps} = '0;
    case (s)
      0:  begin mr = 1; sb = 2'b01; iw = r; pw = r; end
      1:  sb = 2'b10;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pw = z; end
      9:  begin ps = 2'b10; pw = 1; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: h = 1;
      default: ;
    endcase
    return {pw, io, mr, mw, iw, rd, m2r, rw, sa, sb, ao, ps, h};
  endfunction

  task automatic doReset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    expRetired = '0;
  endtask

  // Expected trace: fd unanswered fetch cycles, decode, op-specific states, md unanswered memory cycles
  task automatic runInstr(input logic [3:0] op, input int fd, input int md, input logic z);
    stepT q[$];
    for (int i = 0; i < fd; i++) q.push_back('{0, 1'b0});
    q.push_back('{0, 1'b1});
    q.push_back('{1, 1'($urandom)});
    case (op)
      4'd0: begin q.push_back('{6, 1'($urandom)}); q.push_back('{7, 1'($urandom)}); end
      4'd1: begin
        q.push_back('{2, 1'($urandom)});
        for (int i = 0; i < md; i++) q.push_back('{3, 1'b0});
        q.push_back('{3, 1'b1});
        q.push_back('{4, 1'($urandom)});
      end
      4'd2: begin
        q.push_back('{2, 1'($urandom)});
        for (int i = 0; i < md; i++) q.push_back('{5, 1'b0});
        q.push_back('{5, 1'b1});
      end
      4'd3: q.push_back('{8, 1'($urandom)});
      4'd4: begin q.push_back('{10, 1'($urandom)}); q.push_back('{11, 1'($urandom)}); end
      default: q.push_back('{9, 1'($urandom)});
    endcase
    opcode = op;
    zero = z;
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      @(negedge clk);
      vectors += 2;
      if (state_dbg !== 4'(q[i].st)) begin
        miscompares++;
        $display("FAIL state op%0d step%0d: got %0d want %0d", op, i, state_dbg, q[i].st);
      end
      if (act !== expOut(q[i].st, q[i].rdy, z)) begin
        miscompares++;
        $display("FAIL outputs op%0d step%0d state%0d: got %h want %h", op, i, q[i].st, act, expOut(q[i].st, q[i].rdy, z));
      end
      @(posedge clk);
      #1;
    end
    expRetired++;
    vectors += 2;
    if (retired !== expRetired) begin
      miscompares++;
      $display("FAIL retired op%0d: got %0d want %0d", op, retired, expRetired);
    end
    if (state_dbg !== 4'd0) begin
      miscompares++;
      $display("FAIL back_to_fetch op%0d: got %0d want 0", op, state_dbg);
    end
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #3;
    vectors += 2;
    if (enables !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_enables: got %b want 00000", enables);
    end
    if ({state_dbg, retired, bus_error, illegal} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: state %0d retired %0d be %b il %b want all 0", state_dbg, retired, bus_error, illegal);
    end
    doReset();
  endtask

  task automatic test_rtype();
    runInstr(4'd0, 0, 0, 1'b0);
  endtask

  task automatic test_lw_wait();
    runInstr(4'd1, 0, 2, 1'b0);
  endtask

  task automatic test_beq();
    runInstr(4'd3, 0, 0, 1'b1);
    runInstr(4'd3, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] ops [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    for (int n = 0; n < 40; n++)
      runInstr(ops[$urandom_range(0, 5)], $urandom_range(0, WL - 1), $urandom_range(0, WL - 1), 1'($urandom));
  endtask

  task automatic test_timeout();
    doReset();
    for (int i = 0; i < WL; i++) begin
      @(negedge clk);
      vectors += 2;
      if (state_dbg !== 4'd0) begin
        miscompares++;
        $display("FAIL timeout_wait cycle%0d: state got %0d want 0", i, state_dbg);
      end
      if (mem_read !== 1'b1) begin
        miscompares++;
        $display("FAIL timeout_wait_read cycle%0d: got %b want 1", i, mem_read);
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      vectors++;
      if ({state_dbg, bus_error, illegal, enables} !== {4'd13, 1'b1, 1'b0, 5'b0}) begin
        miscompares++;
        $display("FAIL timeout_fault cycle%0d: state %0d be %b il %b en %b want 13 1 0 00000", i, state_dbg, bus_error, illegal, enables);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_halt();
    doReset();
    opcode = 4'hF;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (state_dbg !== 4'd12 || act !== expOut(12, 1'b0, 1'b0) || retired !== '0) begin
        miscompares++;
        $display("FAIL halt cycle%0d: state %0d out %h retired %0d want 12 %h 0", i, state_dbg, act, retired, expOut(12, 1'b0, 1'b0));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_illegal();
    logic [3:0] op;
    op = 4'($urandom_range(6, 14));
    doReset();
    opcode = op;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({state_dbg, illegal, bus_error, enables} !== {4'd13, 1'b1, 1'b0, 5'b0}) begin
      miscompares++;
      $display("FAIL illegal op%0d: state %0d il %b be %b en %b want 13 1 0 00000", op, state_dbg, illegal, bus_error, enables);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    doReset();
    runInstr(4'd5, 0, 0, 1'b0);
    opcode = 4'd2;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (state_dbg !== 4'd5 || mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_setup: state %0d mw %b want 5 1", state_dbg, mem_write);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || state_dbg !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset_async: mw %b state %0d want 0 0", mem_write, state_dbg);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    expRetired = '0;
    @(negedge clk);
    vectors++;
    if (state_dbg !== 4'd0 || retired !== '0) begin
      miscompares++;
      $display("FAIL midreset_release: state %0d retired %0d want 0 0", state_dbg, retired);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_random();
    test_timeout();
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle sequencer for the 16-bit datapath (IF/ID/EX/MEM/WB stages share one ALU and one memory port). It decodes the 4-bit opcode field and steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, driving the datapath enables and mux selects. It waits on a memory ready handshake with a timeout, and counts retired instructions. It replaces the single-cycle control unit when the processor is built in multicycle form.

Parameters:
WAIT_LIMIT, 8, max cycles a memory access may wait for mem_ready before faulting (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  4  instruction[15:12] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  PC load enable, with the branch condition already folded in
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
reg_dst  out  1  write register: 0=rt[8:6], 1=rd[5:3]
mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 1, 10=sign-extended imm[5:0], 11=reserved
alu_op  out  2  00=add, 01=sub, 10=use funct, 11=reserved
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
halted  out  1  in HALT state
bus_error  out  1  memory timeout fault latched
illegal  out  1  undefined opcode fault latched
retired  out  CNT_W  completed-instruction count
state_dbg  out  4  current state encoding

Behaviour:
- Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 J, 1111 HALT. All other opcodes are illegal.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=12, FAULT=13.
- Reset (asynchronous): state=FETCH, retired=0, wait counter=0, bus_error=0, illegal=0. While reset is high, all enables (pc_write, mem_read, mem_write, ir_write, reg_write) are forced to 0.
- Outputs are combinational from the state register (Moore). The exceptions are ir_write/pc_write in FETCH, which are gated by mem_ready, and pc_write in BRANCH, which is gated by zero. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE. Otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=00 (precomputes branch target).
  - Next state by opcode: LW/SW→MEM_ADDR, R→EXECUTE, BEQ→BRANCH, ADDI→ADDI_EX, J→JUMP, HALT→HALT, illegal→FAULT with illegal latched to 1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: mem_read=1, iord=1. Stays until mem_ready=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH; retire.
- MEM_WRITE: mem_write=1, iord=1. Stays until mem_ready=1, then FETCH; retire.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH; retire.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write=zero.
  - Next FETCH; retire regardless of zero.
- JUMP: pc_source=10, pc_write=1. Next FETCH; retire.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH; retire.
- HALT: halted=1. No enables. Terminal until reset.
- FAULT: no enables. bus_error and illegal hold their latched values. Terminal until reset.
- Retire: retired increments by 1 on the clock edge that leaves a final state to FETCH. It wraps from 2^CNT_W−1 to 0.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ, or MEM_WRITE, and whenever mem_ready=1.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - When it reaches WAIT_LIMIT with mem_ready still 0: next state FAULT, bus_error latched to 1.
  - mem_ready=1 on the limit cycle has priority: the access completes normally.
- Cycle counts with mem_ready=1 throughout: R/ADDI 4 cycles, LW 5, SW 4, BEQ 3, J 3.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - state encodings
  - ALUOp codes
  - ALUSrcB codes
  - PCSource codes
- One sub-module, mem_wait_timer: the saturating wait counter with clear/enable inputs and a timeout output.
- The FSM, output decode, and retire counter stay in multicycle_control.

Test Plan:
- R-type, opcode=0000, mem_ready=1: states 0→1→6→7→0 over 4 cycles; reg_write=1 and reg_dst=1 only in R_WB; retired 0→1.
- LW, mem_ready low for 2 cycles in MEM_READ: stays in state 3 for 3 cycles, then MEM_WB with mem_to_reg=1; total 7 cycles; retired increments once.
- BEQ with zero=1: pc_write=1 and pc_source=01 in BRANCH. Repeat with zero=0: pc_write=0. retired increments in both cases.
- WAIT_LIMIT=4, mem_ready=0 in FETCH: FAULT after 4 wait cycles; bus_error=1; mem_read=0 afterwards; holds until reset.
- Opcodes: 1111 → halted=1 with all enables 0 for 20 cycles; 1010 → FAULT with illegal=1 and bus_error=0.
- Reset asserted mid-MEM_WRITE, between clock edges: mem_write drops to 0 immediately; after release, state_dbg=0 and retired=0.
